// File: rtl/output_bus_scheduler_if.sv
// Handshake and bus signals between the datapath/controller, the scheduler and the host.
interface output_bus_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // datapath side
    logic                  out_push;
    logic [DATA_WIDTH-1:0] out_data;
    logic [31:0]           out_x;
    logic [31:0]           out_y;
    logic [31:0]           out_ch;
    logic                  out_full;

    // controller side
    logic                  in_req;
    logic                  in_done;
    logic                  in_grant;

    // host bus side
    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_WIDTH-1:0] bus_data;
    logic [31:0]           bus_x;
    logic [31:0]           bus_y;
    logic [31:0]           bus_ch;
    logic [1:0]            bus_owner;

    // status
    logic [CNT_W-1:0]      fifo_count;
    logic                  overflow_err;

    // environment view: drives requests and data, observes status
    modport master (
        output out_push, out_data, out_x, out_y, out_ch,
        output in_req, in_done, bus_ready,
        input  out_full, in_grant, bus_valid, bus_data, bus_x, bus_y, bus_ch,
        input  bus_owner, fifo_count, overflow_err
    );

    // scheduler view
    modport slave (
        input  out_push, out_data, out_x, out_y, out_ch,
        input  in_req, in_done, bus_ready,
        output out_full, in_grant, bus_valid, bus_data, bus_x, bus_y, bus_ch,
        output bus_owner, fifo_count, overflow_err
    );
endinterface

// File: rtl/output_bus_scheduler.sv
// Output bus scheduler: buffers tagged datapath outputs in a FIFO and arbitrates
// the shared external bus between controller load phases and output drain.
module output_bus_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BURST_LEN  = 3,
    parameter int unsigned HIGH_WATER = 6
) (
    input  logic                  clk,
    input  logic                  arst_in,
    output_bus_scheduler_if.slave sif
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BST_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IN = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [BST_W-1:0]      burst_q, burst_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  ovf_q;

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [31:0]           mem_x    [FIFO_DEPTH];
    logic [31:0]           mem_y    [FIFO_DEPTH];
    logic [31:0]           mem_ch   [FIFO_DEPTH];

    logic full_c;
    logic bus_valid_c;
    logic push_c;
    logic pop_c;

    assign full_c      = (count_q == CNT_W'(FIFO_DEPTH));
    assign bus_valid_c = (state_q == DRAIN) && (count_q != '0);
    // a pop in the same cycle never frees space for a push into a full FIFO
    assign push_c      = sif.out_push && !full_c;
    assign pop_c       = bus_valid_c && sif.bus_ready;

    // FIFO storage; contents are don't-care until written, outputs are gated by bus_valid
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_data[wr_ptr_q] <= sif.out_data;
            mem_x[wr_ptr_q]    <= sif.out_x;
            mem_y[wr_ptr_q]    <= sif.out_y;
            mem_ch[wr_ptr_q]   <= sif.out_ch;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (sif.out_push && full_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // scheduler state and burst counter registers
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= IDLE;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // bus arbitration: drain above high water, then load requests, then any backlog
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (count_q >= CNT_W'(HIGH_WATER)) begin
                    state_d = DRAIN;
                end else if (sif.in_req) begin
                    state_d = GRANT_IN;
                end else if (count_q != '0) begin
                    state_d = DRAIN;
                end
            end
            GRANT_IN: begin
                if (sif.in_done) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (pop_c) begin
                    if ((burst_q == BST_W'(BURST_LEN - 1)) ||
                        ((count_q == CNT_W'(1)) && !push_c)) begin
                        state_d = IDLE;
                        burst_d = '0;
                    end else begin
                        burst_d = burst_q + BST_W'(1);
                    end
                end else if (count_q == '0) begin
                    state_d = IDLE;
                    burst_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    assign sif.out_full     = full_c;
    assign sif.in_grant     = (state_q == GRANT_IN);
    assign sif.bus_valid    = bus_valid_c;
    assign sif.bus_owner    = 2'(state_q);
    assign sif.fifo_count   = count_q;
    assign sif.overflow_err = ovf_q;
    assign sif.bus_data     = bus_valid_c ? mem_data[rd_ptr_q] : '0;
    assign sif.bus_x        = bus_valid_c ? mem_x[rd_ptr_q]    : '0;
    assign sif.bus_y        = bus_valid_c ? mem_y[rd_ptr_q]    : '0;
    assign sif.bus_ch       = bus_valid_c ? mem_ch[rd_ptr_q]   : '0;
endmodule

// File: tb/tb_output_bus_scheduler.sv
// Bench for output_bus_scheduler: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference of the scheduling rules.
module tb_output_bus_scheduler;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned BURST = 3;
    localparam int unsigned HW    = 6;

    typedef struct {
        logic [31:0] d;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] ch;
    } entry_t;

    logic clk;
    logic arst_in;

    output_bus_scheduler_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) sif ();

    output_bus_scheduler #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .BURST_LEN  (BURST),
        .HIGH_WATER (HW)
    ) dut (
        .clk     (clk),
        .arst_in (arst_in),
        .sif     (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // reference: queue of buffered words, owner 0/1/2, pops in current tenure
    entry_t q[$];
    int     m_owner = 0;
    int     m_burst = 0;
    bit     m_ovf   = 1'b0;

    logic [31:0] t5_d [9];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_owner = 0;
        m_burst = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic check_all();
        int n;
        bit ev;
        n  = q.size();
        ev = (m_owner == 2) && (n > 0);
        chk("owner",    64'(sif.bus_owner),    64'(m_owner));
        chk("grant",    64'(sif.in_grant),     64'(m_owner == 1));
        chk("valid",    64'(sif.bus_valid),    64'(ev));
        chk("count",    64'(sif.fifo_count),   64'(n));
        chk("full",     64'(sif.out_full),     64'(n == DEPTH));
        chk("overflow", 64'(sif.overflow_err), 64'(m_ovf));
        chk("bus_data", 64'(sif.bus_data),     ev ? 64'(q[0].d)  : 64'd0);
        chk("bus_x",    64'(sif.bus_x),        ev ? 64'(q[0].x)  : 64'd0);
        chk("bus_y",    64'(sif.bus_y),        ev ? 64'(q[0].y)  : 64'd0);
        chk("bus_ch",   64'(sif.bus_ch),       ev ? 64'(q[0].ch) : 64'd0);
    endtask

    // advance the reference by one clock using the inputs held during that cycle
    task automatic model_step();
        int     n;
        bit     ev;
        bit     pop;
        bit     push_ok;
        entry_t e;
        n       = q.size();
        ev      = (m_owner == 2) && (n > 0);
        pop     = ev && sif.bus_ready;
        push_ok = sif.out_push && (n < DEPTH);
        if (sif.out_push && (n >= DEPTH)) m_ovf = 1'b1;
        case (m_owner)
            0: begin
                if (n >= HW)          m_owner = 2;
                else if (sif.in_req)  m_owner = 1;
                else if (n > 0)       m_owner = 2;
            end
            1: begin
                if (sif.in_done) m_owner = 0;
            end
            default: begin
                if (pop) begin
                    m_burst++;
                    if ((m_burst == BURST) || ((n == 1) && !push_ok)) begin
                        m_owner = 0;
                        m_burst = 0;
                    end
                end else if (n == 0) begin
                    m_owner = 0;
                    m_burst = 0;
                end
            end
        endcase
        if (pop) void'(q.pop_front());
        if (push_ok) begin
            e.d  = sif.out_data;
            e.x  = sif.out_x;
            e.y  = sif.out_y;
            e.ch = sif.out_ch;
            q.push_back(e);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_push(input logic [31:0] d, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] ch);
        sif.out_push = 1'b1;
        sif.out_data = d;
        sif.out_x    = x;
        sif.out_y    = y;
        sif.out_ch   = ch;
    endtask

    task automatic release_reset();
        @(negedge clk);
        arst_in = 1'b0;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk_reset_zero(input string tag);
        chk({tag, "_owner"}, 64'(sif.bus_owner),    64'd0);
        chk({tag, "_valid"}, 64'(sif.bus_valid),    64'd0);
        chk({tag, "_grant"}, 64'(sif.in_grant),     64'd0);
        chk({tag, "_count"}, 64'(sif.fifo_count),   64'd0);
        chk({tag, "_full"},  64'(sif.out_full),     64'd0);
        chk({tag, "_ovf"},   64'(sif.overflow_err), 64'd0);
        chk({tag, "_data"},  64'(sif.bus_data),     64'd0);
    endtask

    initial begin
        arst_in       = 1'b1;
        sif.out_push  = 1'b0;
        sif.out_data  = '0;
        sif.out_x     = '0;
        sif.out_y     = '0;
        sif.out_ch    = '0;
        sif.in_req    = 1'b0;
        sif.in_done   = 1'b0;
        sif.bus_ready = 1'b0;

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_reset_zero("por");
        model_reset();
        release_reset();

        // single word: valid two cycles after the push, then popped
        set_push(32'h11, 32'd2, 32'd3, 32'd6);
        sif.bus_ready = 1'b1;
        step();
        sif.out_push = 1'b0;
        chk("lat_n1_valid", 64'(sif.bus_valid), 64'd0);
        chk("lat_n1_count", 64'(sif.fifo_count), 64'd1);
        step();
        chk("lat_n2_valid", 64'(sif.bus_valid), 64'd1);
        chk("lat_n2_owner", 64'(sif.bus_owner), 64'd2);
        chk("lat_n2_data",  64'(sif.bus_data),  64'h11);
        chk("lat_n2_x",     64'(sif.bus_x),     64'd2);
        chk("lat_n2_y",     64'(sif.bus_y),     64'd3);
        chk("lat_n2_ch",    64'(sif.bus_ch),    64'd6);
        step();
        chk("lat_done_owner", 64'(sif.bus_owner),  64'd0);
        chk("lat_done_count", 64'(sif.fifo_count), 64'd0);

        // five words, burst of three, one idle cycle, then the load phase
        sif.bus_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push($urandom, $urandom, $urandom, $urandom);
            step();
        end
        sif.out_push = 1'b0;
        chk("b5_count", 64'(sif.fifo_count), 64'd5);
        sif.in_req    = 1'b1;
        sif.bus_ready = 1'b1;
        repeat (3) step();
        chk("b5_idle_owner", 64'(sif.bus_owner),  64'd0);
        chk("b5_idle_count", 64'(sif.fifo_count), 64'd2);
        step();
        chk("b5_grant", 64'(sif.in_grant), 64'd1);
        sif.in_done = 1'b1;
        sif.in_req  = 1'b0;
        step();
        sif.in_done = 1'b0;
        chk("b5_release", 64'(sif.in_grant), 64'd0);
        repeat (3) step();
        chk("b5_empty_count", 64'(sif.fifo_count), 64'd0);
        chk("b5_empty_owner", 64'(sif.bus_owner),  64'd0);

        // high water beats a pending load request
        sif.in_req = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            set_push($urandom, $urandom, $urandom, $urandom);
            step();
        end
        sif.out_push = 1'b0;
        chk("hw_count", 64'(sif.fifo_count), 64'd6);
        sif.in_done = 1'b1;
        step();
        sif.in_done = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk("hw_owner_drain", 64'(sif.bus_owner), 64'd2);
            chk("hw_grant_low",   64'(sif.in_grant),  64'd0);
            step();
        end
        chk("hw_after_count", 64'(sif.fifo_count), 64'd3);
        step();
        chk("hw_grant_after", 64'(sif.in_grant), 64'd1);
        sif.in_req  = 1'b0;
        sif.in_done = 1'b1;
        step();
        sif.in_done = 1'b0;
        repeat (8) step();
        chk("hw_empty", 64'(sif.fifo_count), 64'd0);

        // overflow while the controller holds the bus
        sif.in_req = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            t5_d[i] = $urandom;
            set_push(t5_d[i], $urandom, $urandom, $urandom);
            step();
        end
        sif.out_push = 1'b0;
        chk("ovf_count", 64'(sif.fifo_count),   64'd8);
        chk("ovf_full",  64'(sif.out_full),     64'd1);
        chk("ovf_flag",  64'(sif.overflow_err), 64'd1);
        chk("ovf_grant", 64'(sif.in_grant),     64'd1);

        // stalled drain holds the head, then simultaneous push and pop
        sif.in_req    = 1'b0;
        sif.in_done   = 1'b1;
        sif.bus_ready = 1'b0;
        step();
        sif.in_done = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stall_count", 64'(sif.fifo_count), 64'd8);
            chk("stall_data",  64'(sif.bus_data),   64'(t5_d[0]));
            step();
        end
        sif.bus_ready = 1'b1;
        step();
        set_push(32'hCAFE_0001, 32'd9, 32'd9, 32'd9);
        step();
        sif.out_push = 1'b0;
        chk("pp_count", 64'(sif.fifo_count), 64'd7);
        chk("pp_head",  64'(sif.bus_data),   64'(t5_d[2]));
        repeat (30) step();
        chk("pp_empty", 64'(sif.fifo_count), 64'd0);

        // asynchronous reset in the middle of a drain with four entries
        sif.bus_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_push($urandom, $urandom, $urandom, $urandom);
            step();
        end
        sif.out_push = 1'b0;
        step();
        chk("mid_owner", 64'(sif.bus_owner),  64'd2);
        chk("mid_count", 64'(sif.fifo_count), 64'd4);
        #3;
        arst_in = 1'b1;
        #1;
        chk_reset_zero("midrst");
        model_reset();
        @(posedge clk);
        release_reset();
        chk_reset_zero("postrst");

        // random traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            sif.out_push  = ($urandom_range(99) < 55);
            sif.out_data  = $urandom;
            sif.out_x     = $urandom;
            sif.out_y     = $urandom;
            sif.out_ch    = $urandom;
            sif.in_req    = ($urandom_range(99) < 30);
            sif.in_done   = ($urandom_range(99) < 25);
            sif.bus_ready = ($urandom_range(99) < 65);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/output_bus_scheduler.md
Name: output_bus_scheduler

Overview:
- Buffers tagged output words from the convolution datapath (value plus x/y/ch coordinates) in a small FIFO.
- Schedules a single shared external bus between two users: the controller's input/kernel load phases, and draining the buffered outputs.
- Sits between the controller FSM / output shift structure and the external host interface. The datapath is never stalled by output drain unless the FIFO is full.

Parameters:
- DATA_WIDTH, 32, width of one output value.
- FIFO_DEPTH, 8, output FIFO entries; power of two, >= 2.
- BURST_LEN, 3, maximum pops per DRAIN tenure.
- HIGH_WATER, 6, fill level at or above which drain takes priority over input requests; 1 <= HIGH_WATER <= FIFO_DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- arst_in  in  1  reset, asynchronous, active-high.
- out_push  in  1  datapath offers one tagged output this cycle.
- out_data  in  DATA_WIDTH  output value.
- out_x / out_y / out_ch  in  32 each  coordinate tags.
- out_full  out  1  FIFO full (count == FIFO_DEPTH).
- in_req  in  1  controller requests the bus for a load phase.
- in_done  in  1  controller releases the bus; sampled only while in_grant = 1.
- in_grant  out  1  controller owns the bus.
- bus_valid  out  1  output word presented on the bus.
- bus_ready  in  1  host accepts the word.
- bus_data  out  DATA_WIDTH  value at the FIFO head.
- bus_x / bus_y / bus_ch  out  32 each  tags at the FIFO head.
- bus_owner  out  2  0 = idle, 1 = input, 2 = output.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow_err  out  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (async assert, any state): state IDLE, FIFO pointers and count cleared, FIFO contents discarded, burst counter 0.
  - All outputs 0 during and after reset: in_grant, bus_valid, bus_data/x/y/ch, bus_owner, fifo_count, overflow_err, out_full.
- FIFO:
  - Registered pointers, show-ahead head. Push is accepted iff out_push && !out_full.
  - A push while full is dropped and sets overflow_err. A same-cycle pop does not make room for it.
  - Pop iff bus_valid && bus_ready.
  - Push and pop in the same non-full cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, GRANT_IN, DRAIN. Registered; bus_owner follows the state encoding.
- IDLE priority, evaluated each cycle:
  1. count >= HIGH_WATER -> DRAIN.
  2. else in_req -> GRANT_IN.
  3. else count > 0 -> DRAIN.
  4. else stay in IDLE.
- GRANT_IN:
  - in_grant = 1 and bus_valid = 0.
  - Stays until in_done = 1, then goes to IDLE in the next cycle. in_grant drops in that same cycle.
  - No preemption: the FIFO may fill and out_full may assert while in GRANT_IN.
- DRAIN:
  - bus_valid = (count > 0). bus_* show the FIFO head.
  - While bus_valid && !bus_ready, bus_* are held stable.
  - The burst counter increments on each pop.
  - Exit to IDLE after the BURST_LEN-th pop, or when count becomes 0 after a pop with no same-cycle push.
  - The burst counter clears on exit.
  - in_grant = 0 throughout.
- Latency: a push into an empty FIFO with the block in IDLE and in_req = 0 gives bus_valid two cycles later. Cycle N+1 is IDLE->DRAIN; cycle N+2 is valid.
- Fairness: when DRAIN ends on BURST_LEN with a pending in_req and count < HIGH_WATER, GRANT_IN follows after one IDLE cycle.
- in_done outside GRANT_IN is ignored. in_req may be held through GRANT_IN.
- overflow_err clears only on reset.

Test Plan:
- Reset mid-DRAIN with 4 entries, then deassert reset -> fifo_count = 0, bus_valid = 0, bus_owner = 0, overflow_err = 0.
- Push 1 word (data 0x11, x=2, y=3, ch=6) with bus_ready = 1 -> bus_valid high exactly 2 cycles after the push with matching tags; popped; back to IDLE.
- Push 5 words, in_req = 1, bus_ready = 1 -> 3 pops (burst), one IDLE cycle, in_grant = 1. Pulse in_done -> remaining 2 words drain.
- Push 6 words while in_req = 1 in IDLE -> DRAIN wins (HIGH_WATER); in_grant stays 0 until the burst ends.
- In GRANT_IN, push 9 words with no in_done -> out_full after 8 pushes, 9th dropped, overflow_err = 1, fifo_count = 8.
- In DRAIN, hold bus_ready = 0 for 4 cycles -> bus_* stable and count unchanged. Then push and pop in the same cycle -> count unchanged and FIFO order preserved.
